// File: rtl/link_blk_fifo.sv
// Block-granular single-clock link FIFO. Words are written into fixed-size blocks,
// and a block becomes readable only after it is committed (full or flushed).
module link_blk_fifo #(
    parameter int DATA_WIDTH     = 256,
    parameter int OFST_WIDTH     = 7,
    parameter int BLK_ADDR_WIDTH = 3,
    parameter int AFULL_MARGIN   = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH-1:0]              iWR_DATA,
    input  logic                               iWR_VALID,
    input  logic                               iWR_FLUSH,
    output logic                               oWR_FULL,
    output logic                               oWR_AFULL,
    output logic [OFST_WIDTH-1:0]              oWR_OFST,
    output logic                               oEMPTY,
    output logic                               oRD_BLK_AVAIL,
    output logic [OFST_WIDTH:0]                oRD_BLK_LEN,
    output logic [BLK_ADDR_WIDTH:0]            oRD_BLK_CNT,
    input  logic                               iRD_EN,
    output logic [DATA_WIDTH-1:0]              oRD_DATA,
    output logic                               oRD_DATA_V,
    output logic                               oRD_LAST,
    output logic [BLK_ADDR_WIDTH+OFST_WIDTH:0] oSTAT_WORDS,
    output logic                               oSTAT_OVERFLOW,
    output logic                               oSTAT_UNDERFLOW,
    output logic [15:0]                        oSTAT_DROP_CNT,
    input  logic                               iSTAT_CLR,
    input  logic [BLK_ADDR_WIDTH+OFST_WIDTH:0] iLEVEL_WR,
    input  logic                               iLEVEL_WR_EN,
    output logic [BLK_ADDR_WIDTH+OFST_WIDTH:0] oLEVEL_RD
);
    localparam int WW        = BLK_ADDR_WIDTH + OFST_WIDTH + 1;
    localparam int NUM_BLKS  = 1 << BLK_ADDR_WIDTH;
    localparam int BLK_WORDS = 1 << OFST_WIDTH;
    localparam int DEPTH     = NUM_BLKS * BLK_WORDS;

    localparam logic [OFST_WIDTH-1:0]   OFST_ONE  = OFST_WIDTH'(1);
    localparam logic [OFST_WIDTH-1:0]   OFST_LAST = OFST_WIDTH'(BLK_WORDS - 1);
    localparam logic [OFST_WIDTH:0]     LEN_FULL  = (OFST_WIDTH+1)'(BLK_WORDS);
    localparam logic [BLK_ADDR_WIDTH:0] BLK_ONE   = (BLK_ADDR_WIDTH+1)'(1);
    localparam logic [BLK_ADDR_WIDTH:0] BLK_ALL   = (BLK_ADDR_WIDTH+1)'(NUM_BLKS);
    localparam logic [WW-1:0]           WORDS_ONE = WW'(1);
    localparam logic [WW-1:0]           WORDS_BLK = WW'(BLK_WORDS);
    localparam logic [WW-1:0]           WORDS_ALL = WW'(DEPTH);
    localparam logic [WW-1:0]           WORDS_AF  = WW'(AFULL_MARGIN);

    logic [DATA_WIDTH-1:0]     mem [DEPTH];
    logic [DATA_WIDTH-1:0]     rd_word_q;

    logic [OFST_WIDTH-1:0]     ofst_wa_q, ofst_wa_d, ofst_ra_q, ofst_ra_d;
    logic [BLK_ADDR_WIDTH:0]   blk_wa_q, blk_wa_d, blk_ra_q, blk_ra_d;
    logic [BLK_ADDR_WIDTH:0]   blk_cnt_q, blk_cnt_d;
    logic [OFST_WIDTH:0]       len_q [NUM_BLKS];
    logic [OFST_WIDTH:0]       len_d [NUM_BLKS];
    logic [WW-1:0]             words_q, words_d, level_q, level_d;
    logic                      full_q, full_d, afull_q, afull_d, empty_q, empty_d;
    logic                      rd_v_q, rd_v_d, rd_last_q, rd_last_d;
    logic                      ovf_q, ovf_d, udf_q, udf_d;
    logic [15:0]               drop_cnt_q, drop_cnt_d;

    logic                      avail, wr_acc, wr_drop, rd_acc;
    logic                      auto_commit, commit, retire;
    logic [OFST_WIDTH:0]       commit_len, head_len;
    logic [BLK_ADDR_WIDTH+OFST_WIDTH-1:0] wr_addr, rd_addr;

    // Next-state logic. The open block shares its slot with the head block only
    // when all slots are committed, which is exactly when writes are refused.
    always_comb begin
        avail       = (blk_cnt_q != '0);
        wr_acc      = iWR_VALID & ~full_q;
        wr_drop     = iWR_VALID & full_q;
        rd_acc      = iRD_EN & avail;
        wr_addr     = {blk_wa_q[BLK_ADDR_WIDTH-1:0], ofst_wa_q};
        rd_addr     = {blk_ra_q[BLK_ADDR_WIDTH-1:0], ofst_ra_q};
        head_len    = len_q[blk_ra_q[BLK_ADDR_WIDTH-1:0]];
        auto_commit = wr_acc & (ofst_wa_q == OFST_LAST);
        commit      = auto_commit | (iWR_FLUSH & ((ofst_wa_q != '0) | wr_acc));
        commit_len  = auto_commit ? LEN_FULL
                                  : ({1'b0, ofst_wa_q} + {{OFST_WIDTH{1'b0}}, wr_acc});
        retire      = rd_acc & (({1'b0, ofst_ra_q} + {{OFST_WIDTH{1'b0}}, 1'b1}) == head_len);

        ofst_wa_d = ofst_wa_q;
        blk_wa_d  = blk_wa_q;
        len_d     = len_q;
        if (commit) begin
            ofst_wa_d = '0;
            blk_wa_d  = blk_wa_q + BLK_ONE;
            len_d[blk_wa_q[BLK_ADDR_WIDTH-1:0]] = commit_len;
        end else if (wr_acc) begin
            ofst_wa_d = ofst_wa_q + OFST_ONE;
        end

        ofst_ra_d = ofst_ra_q;
        blk_ra_d  = blk_ra_q;
        if (retire) begin
            ofst_ra_d = '0;
            blk_ra_d  = blk_ra_q + BLK_ONE;
        end else if (rd_acc) begin
            ofst_ra_d = ofst_ra_q + OFST_ONE;
        end

        blk_cnt_d = blk_cnt_q;
        if (commit) blk_cnt_d = blk_cnt_d + BLK_ONE;
        if (retire) blk_cnt_d = blk_cnt_d - BLK_ONE;

        // A partial block still reserves its whole slot, so pad it on commit.
        words_d = words_q;
        if (wr_acc) words_d = words_d + WORDS_ONE;
        if (commit) words_d = words_d + (WORDS_BLK - WW'(commit_len));
        if (retire) words_d = words_d - WORDS_BLK;

        full_d    = (blk_cnt_d == BLK_ALL);
        afull_d   = ((WORDS_ALL - words_d) <= WORDS_AF);
        empty_d   = (words_d == '0);
        rd_v_d    = rd_acc;
        rd_last_d = retire;

        ovf_d      = iSTAT_CLR ? 1'b0 : ovf_q;
        udf_d      = iSTAT_CLR ? 1'b0 : udf_q;
        drop_cnt_d = iSTAT_CLR ? 16'd0 : drop_cnt_q;
        if (wr_drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_d != 16'hFFFF) drop_cnt_d = drop_cnt_d + 16'd1;
        end
        if (iRD_EN & ~avail) udf_d = 1'b1;

        level_d = level_q;
        if (iLEVEL_WR_EN)          level_d = iLEVEL_WR;
        else if (words_q > level_q) level_d = words_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ofst_wa_q  <= '0;
            blk_wa_q   <= '0;
            ofst_ra_q  <= '0;
            blk_ra_q   <= '0;
            blk_cnt_q  <= '0;
            words_q    <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            empty_q    <= 1'b1;
            rd_v_q     <= 1'b0;
            rd_last_q  <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            drop_cnt_q <= '0;
            level_q    <= '0;
            for (int i = 0; i < NUM_BLKS; i++) len_q[i] <= '0;
        end else begin
            ofst_wa_q  <= ofst_wa_d;
            blk_wa_q   <= blk_wa_d;
            ofst_ra_q  <= ofst_ra_d;
            blk_ra_q   <= blk_ra_d;
            blk_cnt_q  <= blk_cnt_d;
            words_q    <= words_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            empty_q    <= empty_d;
            rd_v_q     <= rd_v_d;
            rd_last_q  <= rd_last_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            drop_cnt_q <= drop_cnt_d;
            level_q    <= level_d;
            len_q      <= len_d;
        end
    end

    // Simple dual-port RAM with a registered read; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_addr] <= iWR_DATA;
        if (rd_acc) rd_word_q <= mem[rd_addr];
    end

    always_comb begin
        oWR_FULL        = full_q;
        oWR_AFULL       = afull_q;
        oWR_OFST        = ofst_wa_q;
        oEMPTY          = empty_q;
        oRD_BLK_AVAIL   = avail;
        oRD_BLK_LEN     = avail ? head_len : '0;
        oRD_BLK_CNT     = blk_cnt_q;
        oRD_DATA        = rd_v_q ? rd_word_q : '0;
        oRD_DATA_V      = rd_v_q;
        oRD_LAST        = rd_last_q;
        oSTAT_WORDS     = words_q;
        oSTAT_OVERFLOW  = ovf_q;
        oSTAT_UNDERFLOW = udf_q;
        oSTAT_DROP_CNT  = drop_cnt_q;
        oLEVEL_RD       = level_q;
    end
endmodule

// File: tb/tb_link_blk_fifo.sv
// Self-checking bench for link_blk_fifo: a directed vector table, hand-written
// corner sequences and a randomized run against a queue-based block model.
module tb_link_blk_fifo;
    localparam int DW    = 256;
    localparam int OW    = 7;
    localparam int BW    = 3;
    localparam int WW    = BW + OW + 1;
    localparam int BLK   = 128;
    localparam int NBLK  = 8;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [DW-1:0]   iWR_DATA;
    logic            iWR_VALID, iWR_FLUSH, iRD_EN, iSTAT_CLR, iLEVEL_WR_EN;
    logic [WW-1:0]   iLEVEL_WR;
    logic            oWR_FULL, oWR_AFULL, oEMPTY, oRD_BLK_AVAIL;
    logic [OW-1:0]   oWR_OFST;
    logic [OW:0]     oRD_BLK_LEN;
    logic [BW:0]     oRD_BLK_CNT;
    logic [DW-1:0]   oRD_DATA;
    logic            oRD_DATA_V, oRD_LAST, oSTAT_OVERFLOW, oSTAT_UNDERFLOW;
    logic [WW-1:0]   oSTAT_WORDS, oLEVEL_RD;
    logic [15:0]     oSTAT_DROP_CNT;

    link_blk_fifo #(.DATA_WIDTH(DW), .OFST_WIDTH(OW), .BLK_ADDR_WIDTH(BW), .AFULL_MARGIN(2)) dut (
        .clk(clk), .rst(rst),
        .iWR_DATA(iWR_DATA), .iWR_VALID(iWR_VALID), .iWR_FLUSH(iWR_FLUSH),
        .oWR_FULL(oWR_FULL), .oWR_AFULL(oWR_AFULL), .oWR_OFST(oWR_OFST),
        .oEMPTY(oEMPTY), .oRD_BLK_AVAIL(oRD_BLK_AVAIL), .oRD_BLK_LEN(oRD_BLK_LEN),
        .oRD_BLK_CNT(oRD_BLK_CNT), .iRD_EN(iRD_EN), .oRD_DATA(oRD_DATA),
        .oRD_DATA_V(oRD_DATA_V), .oRD_LAST(oRD_LAST), .oSTAT_WORDS(oSTAT_WORDS),
        .oSTAT_OVERFLOW(oSTAT_OVERFLOW), .oSTAT_UNDERFLOW(oSTAT_UNDERFLOW),
        .oSTAT_DROP_CNT(oSTAT_DROP_CNT), .iSTAT_CLR(iSTAT_CLR),
        .iLEVEL_WR(iLEVEL_WR), .iLEVEL_WR_EN(iLEVEL_WR_EN), .oLEVEL_RD(oLEVEL_RD)
    );

    // Reference model: open block words, committed words in order, block lengths.
    logic [DW-1:0] open_words[$];
    logic [DW-1:0] data_q[$];
    int            lens[$];
    int            head_rd, m_drop, m_level;
    bit            m_ovf, m_udf, e_rd_v, e_rd_last;
    logic [DW-1:0] e_rd_data;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic        wv;
        logic        fl;
        logic        re;
        logic        clr;
        logic [31:0] wd;
        int          e_ofst;
        int          e_words;
        int          e_cnt;
        int          e_len;
        logic        e_v;
        logic        e_last;
        logic [31:0] e_data;
        logic        e_empty;
        logic        e_udf;
    } vec_t;
    vec_t vecs [11];

    int first_af, pulses, last_at, max_cnt, seq_n, rand_lasts;

    function automatic int mWords();
        return BLK * lens.size() + open_words.size();
    endfunction

    task automatic checkVal(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic modelStep(input logic r, input logic wv, input logic [DW-1:0] wd, input logic fl,
                             input logic re, input logic clr, input logic lwe, input logic [WW-1:0] lw);
        int  wpre;
        bit  fpre, apre;
        if (r) begin
            open_words.delete(); data_q.delete(); lens.delete();
            head_rd = 0; m_drop = 0; m_level = 0; m_ovf = 0; m_udf = 0;
            e_rd_v = 0; e_rd_last = 0; e_rd_data = '0;
            return;
        end
        wpre = mWords();
        fpre = (lens.size() == NBLK);
        apre = (lens.size() != 0);
        e_rd_v = 0; e_rd_last = 0; e_rd_data = '0;
        if (re && apre) begin
            e_rd_v = 1;
            e_rd_data = data_q.pop_front();
            head_rd++;
            if (head_rd == lens[0]) begin
                e_rd_last = 1;
                void'(lens.pop_front());
                head_rd = 0;
            end
        end
        if (wv && !fpre) open_words.push_back(wd);
        if (open_words.size() == BLK || (fl && open_words.size() > 0)) begin
            lens.push_back(open_words.size());
            foreach (open_words[i]) data_q.push_back(open_words[i]);
            open_words.delete();
        end
        if (clr) begin m_ovf = 0; m_udf = 0; m_drop = 0; end
        if (wv && fpre) begin
            m_ovf = 1;
            if (m_drop < 65535) m_drop++;
        end
        if (re && !apre) m_udf = 1;
        if (lwe) m_level = int'(lw);
        else if (wpre > m_level) m_level = wpre;
    endtask

    task automatic checkOutput();
        int w;
        w = mWords();
        checkVal("wr_full",   DW'(oWR_FULL),        DW'(lens.size() == NBLK));
        checkVal("wr_afull",  DW'(oWR_AFULL),       DW'((DEPTH - w) <= 2));
        checkVal("wr_ofst",   DW'(oWR_OFST),        DW'(open_words.size()));
        checkVal("empty",     DW'(oEMPTY),          DW'(w == 0));
        checkVal("blk_avail", DW'(oRD_BLK_AVAIL),   DW'(lens.size() != 0));
        checkVal("blk_len",   DW'(oRD_BLK_LEN),     DW'(lens.size() != 0 ? lens[0] : 0));
        checkVal("blk_cnt",   DW'(oRD_BLK_CNT),     DW'(lens.size()));
        checkVal("rd_v",      DW'(oRD_DATA_V),      DW'(e_rd_v));
        checkVal("rd_data",   oRD_DATA,             e_rd_data);
        checkVal("rd_last",   DW'(oRD_LAST),        DW'(e_rd_last));
        checkVal("words",     DW'(oSTAT_WORDS),     DW'(w));
        checkVal("overflow",  DW'(oSTAT_OVERFLOW),  DW'(m_ovf));
        checkVal("underflow", DW'(oSTAT_UNDERFLOW), DW'(m_udf));
        checkVal("drop_cnt",  DW'(oSTAT_DROP_CNT),  DW'(m_drop));
        checkVal("level",     DW'(oLEVEL_RD),       DW'(m_level));
    endtask

    task automatic applyStimulus(input logic r, input logic wv, input logic [DW-1:0] wd, input logic fl,
                                 input logic re, input logic clr, input logic lwe, input logic [WW-1:0] lw);
        rst = r; iWR_VALID = wv; iWR_DATA = wd; iWR_FLUSH = fl;
        iRD_EN = re; iSTAT_CLR = clr; iLEVEL_WR_EN = lwe; iLEVEL_WR = lw;
        @(posedge clk);
        #1;
        modelStep(r, wv, wd, fl, re, clr, lwe, lw);
        checkOutput();
    endtask

    task automatic cyc(input logic wv, input logic [DW-1:0] wd, input logic fl, input logic re);
        applyStimulus(1'b0, wv, wd, fl, re, 1'b0, 1'b0, '0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        rst = 1'b1; iWR_VALID = 1'b0; iWR_DATA = '0; iWR_FLUSH = 1'b0;
        iRD_EN = 1'b0; iSTAT_CLR = 1'b0; iLEVEL_WR_EN = 1'b0; iLEVEL_WR = '0;

        //          wv    fl    re    clr   wd       ofst words cnt len  v     last  data     empty udf
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hA1, 1, 1,   0, 0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hB2, 2, 2,   0, 0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hC3, 0, 128, 1, 3, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  0, 128, 1, 3, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  0, 128, 1, 3, 1'b1, 1'b0, 32'hA1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  0, 128, 1, 3, 1'b1, 1'b0, 32'hB2, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  0, 0,   0, 0, 1'b1, 1'b1, 32'hC3, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  0, 0,   0, 0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hD4, 0, 128, 1, 1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  0, 0,   0, 0, 1'b1, 1'b1, 32'hD4, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  0, 0,   0, 0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0};

        doReset();
        checkVal("rst_empty", DW'(oEMPTY), DW'(1));
        checkVal("rst_words", DW'(oSTAT_WORDS), DW'(0));

        for (int k = 0; k < 11; k++) begin
            applyStimulus(1'b0, vecs[k].wv, DW'(vecs[k].wd), vecs[k].fl, vecs[k].re, vecs[k].clr, 1'b0, '0);
            checkVal("tbl_ofst",  DW'(oWR_OFST),        DW'(vecs[k].e_ofst));
            checkVal("tbl_words", DW'(oSTAT_WORDS),     DW'(vecs[k].e_words));
            checkVal("tbl_cnt",   DW'(oRD_BLK_CNT),     DW'(vecs[k].e_cnt));
            checkVal("tbl_len",   DW'(oRD_BLK_LEN),     DW'(vecs[k].e_len));
            checkVal("tbl_v",     DW'(oRD_DATA_V),      DW'(vecs[k].e_v));
            checkVal("tbl_last",  DW'(oRD_LAST),        DW'(vecs[k].e_last));
            checkVal("tbl_data",  oRD_DATA,             DW'(vecs[k].e_data));
            checkVal("tbl_empty", DW'(oEMPTY),          DW'(vecs[k].e_empty));
            checkVal("tbl_udf",   DW'(oSTAT_UNDERFLOW), DW'(vecs[k].e_udf));
        end

        // One full block written then read back.
        doReset();
        for (int i = 0; i < BLK; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
        checkVal("blk1_cnt", DW'(oRD_BLK_CNT), DW'(1));
        checkVal("blk1_len", DW'(oRD_BLK_LEN), DW'(128));
        checkVal("blk1_words", DW'(oSTAT_WORDS), DW'(128));
        pulses = 0; last_at = -1;
        for (int i = 0; i < BLK; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b1);
            if (oRD_DATA_V === 1'b1) pulses++;
            if (oRD_LAST === 1'b1) last_at = i;
        end
        checkVal("blk1_pulses", DW'(pulses), DW'(128));
        checkVal("blk1_last_at", DW'(last_at), DW'(127));
        checkVal("blk1_empty", DW'(oEMPTY), DW'(1));

        // Fill every slot, then overflow, clear and drain.
        doReset();
        first_af = -1;
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, DW'(1000 + i), 1'b0, 1'b0);
            if (oWR_AFULL === 1'b1 && first_af < 0) first_af = i;
        end
        checkVal("fill_afull_first", DW'(first_af), DW'(1021));
        checkVal("fill_full", DW'(oWR_FULL), DW'(1));
        for (int i = 0; i < 3; i++) cyc(1'b1, DW'(77), 1'b0, 1'b0);
        checkVal("fill_drop_cnt", DW'(oSTAT_DROP_CNT), DW'(3));
        checkVal("fill_overflow", DW'(oSTAT_OVERFLOW), DW'(1));
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        checkVal("clr_drop_cnt", DW'(oSTAT_DROP_CNT), DW'(0));
        checkVal("clr_overflow", DW'(oSTAT_OVERFLOW), DW'(0));
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b0, 1'b1);
        checkVal("drain_empty", DW'(oEMPTY), DW'(1));

        // Watermark with partial-commit padding, then reset mid-block.
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        checkVal("wm_load0", DW'(oLEVEL_RD), DW'(0));
        for (int i = 0; i < 44; i++) cyc(1'b1, DW'(i), (i == 43), 1'b0);
        for (int i = 0; i < 172; i++) cyc(1'b1, DW'(500 + i), 1'b0, 1'b0);
        checkVal("wm_words300", DW'(oSTAT_WORDS), DW'(300));
        for (int i = 0; i < 2 * BLK; i++) cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        checkVal("wm_level", DW'(oLEVEL_RD), DW'(300));
        checkVal("wm_words_left", DW'(oSTAT_WORDS), DW'(44));
        for (int i = 0; i < 3; i++) cyc(1'b1, DW'(900 + i), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, DW'(999), 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkVal("midrst_words", DW'(oSTAT_WORDS), DW'(0));
        checkVal("midrst_ofst", DW'(oWR_OFST), DW'(0));
        checkVal("midrst_empty", DW'(oEMPTY), DW'(1));
        checkVal("midrst_level", DW'(oLEVEL_RD), DW'(0));
        checkVal("midrst_cnt", DW'(oRD_BLK_CNT), DW'(0));

        // Randomized traffic across many pointer wraps.
        doReset();
        seq_n = 0; max_cnt = 0; rand_lasts = 0;
        for (int c = 0; c < 5000; c++) begin
            logic wv, fl, re, clr, lwe;
            wv  = ($urandom_range(0, 99) < 60);
            fl  = ($urandom_range(0, 99) < 3);
            re  = ($urandom_range(0, 99) < 55);
            clr = ($urandom_range(0, 199) == 0);
            lwe = ($urandom_range(0, 499) == 0);
            applyStimulus(1'b0, wv, DW'(seq_n), fl, re, clr, lwe, WW'($urandom_range(0, 1023)));
            if (wv) seq_n++;
            if (int'(oRD_BLK_CNT) > max_cnt) max_cnt = int'(oRD_BLK_CNT);
            if (oRD_LAST === 1'b1) rand_lasts++;
        end
        checkVal("rand_cnt_le8", DW'(max_cnt <= NBLK), DW'(1));
        checkVal("rand_blocks_gt16", DW'(rand_lasts > 16), DW'(1));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
